// File: rtl/sd_reader_pkg.sv
// sd_reader_pkg -- shared defaults and the reader state type for sd_stream_reader.
//   SD_ADDR_W / SD_DATA_W / SD_FIFO_DEPTH : parameter defaults for the reader
//   state_t                               : reader control states
package sd_reader_pkg;

  localparam int SD_ADDR_W     = 8;
  localparam int SD_DATA_W     = 11;
  localparam int SD_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/sd_reader_fifo.sv
// sd_reader_fifo -- synchronous show-ahead FIFO with occupancy output.
//   clk, reset (async active-low), flush (sync clear)
//   wr_en/wr_data : push (ignored when full; the caller's credit check prevents it)
//   rd_en         : pop head when valid
//   rd_data       : head entry, forced to zero while empty
//   valid, count  : not-empty flag and occupancy
module sd_reader_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full;

  assign count   = wr_ptr - rd_ptr;
  assign valid   = (count != '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // Zero while empty so reset/flush leave the stream outputs at 0.
  assign rd_data = valid ? mem[rd_ptr[AW-1:0]] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && valid) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full && !flush) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sd_stream_reader.sv
// sd_stream_reader -- streams a block of samples from a BRAM read port into a
// valid/ready sample stream through a small credit-controlled FIFO.
//   clk, reset (async active-low)
//   start/start_addr/len : begin a block (len 0 just pulses done)
//   abort                : cancel current block, flush everything, no done
//   mem_en/mem_addr/mem_dout : BRAM read port, data returns READ_LAT cycles later
//   out_valid/out_ready/out_data/out_last : sample stream, out_last on block end
//   busy (not IDLE), done (one-cycle pulse at block completion)
// Optional: define SD_READER_LOOP_EN to add input 'loop', which replays the
// block from the latched start address instead of finishing.
module sd_stream_reader
  import sd_reader_pkg::*;
#(
  parameter int ADDR_W     = SD_ADDR_W,
  parameter int DATA_W     = SD_DATA_W,
  parameter int READ_LAT   = 1,
  parameter int FIFO_DEPTH = SD_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              abort,
`ifdef SD_READER_LOOP_EN
  input  logic              loop,
`endif
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(FIFO_DEPTH) + 2;

  state_t                    state;
  logic [ADDR_W-1:0]         base_addr, nxt_addr;
  logic [ADDR_W:0]           blk_len, rem;
  logic                      mem_last;
  logic [READ_LAT-1:0]       vld_pipe, last_pipe;
  logic [$clog2(FIFO_DEPTH):0] occ;
  logic [DATA_W:0]           fifo_rd;
  logic [CW-1:0]             pending;
  logic                      xfer, xfer_last, flush, issue, loop_en;

`ifdef SD_READER_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign xfer      = out_valid & out_ready;
  assign xfer_last = xfer & out_last;
  assign flush     = abort & busy;
  assign out_data  = fifo_rd[DATA_W-1:0];
  assign out_last  = fifo_rd[DATA_W];

  // Slots already claimed: buffered + on the bus + in the read pipe. A pop
  // this edge frees one, which keeps 1 beat/cycle with the minimum depth.
  always_comb begin
    pending = CW'(occ) + CW'(mem_en);
    for (int i = 0; i < READ_LAT; i++) pending = pending + CW'(vld_pipe[i]);
    if (xfer) pending = pending - CW'(1);
  end

  assign issue = (state == READ) && !abort && (rem != '0) &&
                 (pending < CW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      base_addr <= '0;
      nxt_addr  <= '0;
      blk_len   <= '0;
      rem       <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      mem_last  <= 1'b0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      mem_en   <= 1'b0;
      mem_last <= 1'b0;
      // Read-return tracking: stage READ_LAT-1 lines up with mem_dout.
      vld_pipe[0]  <= mem_en;
      last_pipe[0] <= mem_last;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end

      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              base_addr <= start_addr;
              nxt_addr  <= start_addr;
              blk_len   <= len;
              rem       <= len;
              state     <= READ;
            end
          end
        end
        READ: begin
          if (abort) state <= IDLE;
          else if (mem_en && mem_last) state <= DRAIN;
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
          end else if (xfer_last) begin
            if (loop_en) begin
              nxt_addr <= base_addr;
              rem      <= blk_len;
              state    <= READ;
            end else begin
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (issue) begin
        mem_en   <= 1'b1;
        mem_addr <= nxt_addr;
        mem_last <= (rem == (ADDR_W+1)'(1));
        nxt_addr <= nxt_addr + ADDR_W'(1);
        rem      <= rem - (ADDR_W+1)'(1);
      end

      // Returns still in flight belong to the cancelled block.
      if (flush) begin
        vld_pipe  <= '0;
        last_pipe <= '0;
      end
    end
  end

  sd_reader_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .wr_en   (vld_pipe[READ_LAT-1]),
    .wr_data ({last_pipe[READ_LAT-1], mem_dout}),
    .rd_en   (out_ready),
    .rd_data (fifo_rd),
    .valid   (out_valid),
    .count   (occ)
  );

endmodule

// File: tb/tb_sd_stream_reader.sv
// tb_sd_stream_reader -- scoreboard bench for sd_stream_reader (READ_LAT=1,
// FIFO_DEPTH=4). A BRAM model returns tb_mem[addr] one cycle after mem_en.
// Expected beats and addresses are queued when a block is launched and popped
// by a negedge monitor as the DUT issues reads and transfers beats.
module tb_sd_stream_reader;
  localparam int AW = 8, DW = 11, DEPTH = 4;

  logic          clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   len = '0;
  logic          mem_en, out_valid, out_last, busy, done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout = '0, out_data;
`ifdef SD_READER_LOOP_EN
  logic          loop = 1'b0;
`endif

  int vectors = 0, errs = 0;
  logic [DW-1:0] tb_mem [256];
  logic [DW:0]   exp_q [$];
  logic [AW-1:0] addr_q [$];
  int cyc = 0, iss = 0, xf = 0, done_cnt = 0;
  int last_cyc = 0, done_cyc = 0, first_cyc = 0;
  int iss_base = 0, xf_base = 0, rmode = 0, rc = 0;
  logic          stall_prev = 1'b0;
  logic [DW:0]   prev_beat = '0;

  always #5 clk = ~clk;

  sd_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .len(len), .abort(abort),
`ifdef SD_READER_LOOP_EN
    .loop(loop),
`endif
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always @(posedge clk) if (mem_en) mem_dout <= tb_mem[mem_addr];

  task automatic chk(input string tag, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor: reads issued, beats transferred, stall stability, done pulses.
  always @(negedge clk) begin
    cyc++;
    if (mem_en) begin
      iss++;
      chk("addr_pending", int'(addr_q.size() > 0), 1);
      if (addr_q.size() > 0) chk("mem_addr", mem_addr, addr_q.pop_front());
      chk("outstanding_le_depth", int'(((iss - iss_base) - (xf - xf_base)) <= DEPTH), 1);
    end
    if (stall_prev && out_valid) chk("stall_hold", {out_last, out_data}, prev_beat);
    if (out_valid && out_ready) begin
      chk("beat_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("beat", {out_last, out_data}, exp_q.pop_front());
      if (xf == xf_base) first_cyc = cyc;
      xf++;
      if (out_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    stall_prev = out_valid && !out_ready;
    prev_beat  = {out_last, out_data};
  end

  // out_ready pattern: 0 = always, 1 = one cycle in three, 2 = never.
  initial forever begin
    @(posedge clk); #1;
    out_ready = (rmode == 0) || (rmode == 1 && (rc % 3) == 0);
    rc++;
  end

  task automatic push_block(input logic [AW-1:0] sa, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), tb_mem[AW'(int'(sa) + i)]});
      addr_q.push_back(AW'(int'(sa) + i));
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] sa, input int n);
    iss_base = iss;
    xf_base = xf;
    start_addr = sa;
    len = (AW+1)'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  task automatic run_block(input logic [AW-1:0] sa, input int n, input bit full_chk);
    int d0 = done_cnt;
    int lat = 0;
    push_block(sa, n);
    pulse_start(sa, n);
    if (full_chk) begin
      while (!out_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("first_valid_lat", lat, 3);
    end
    wait_done(d0);
    chk("done_count", done_cnt - d0, 1);
    chk("done_after_last", done_cyc - last_cyc, 1);
    chk("beats", xf - xf_base, n);
    chk("sb_empty", exp_q.size(), 0);
    chk("busy_end", busy, 0);
    if (full_chk) chk("throughput", last_cyc - first_cyc, n - 1);
  endtask

  initial begin
    int d0, i0, t;
    for (int i = 0; i < 256; i++) tb_mem[i] = DW'(i);

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_out_data", {out_last, out_data}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Full 256-sample block, address wrap, and a stalled stream.
    run_block(8'd0, 256, 1'b1);
    run_block(8'd250, 10, 1'b0);
    rmode = 1;
    run_block(8'd100, 20, 1'b0);
    rmode = 0;
    @(posedge clk); #1;

    // Abort on the 5th transfer of a 16-sample block.
    d0 = done_cnt;
    push_block(8'h40, 16);
    pulse_start(8'h40, 16);
    t = 0;
    while (!((xf - xf_base) == 4 && out_valid) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_xfers", xf - xf_base, 5);
    exp_q.delete();
    addr_q.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt - d0, 0);
    run_block(8'h80, 2, 1'b0);

    // Asynchronous reset while draining a stalled block.
    rmode = 2;
    @(posedge clk); #1;
    push_block(8'd10, 3);
    pulse_start(8'd10, 3);
    repeat (8) @(posedge clk);
    #1;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    d0 = done_cnt;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mem", {mem_en, mem_addr}, 0);
    chk("mid_rst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    addr_q.delete();
    rmode = 0;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_no_done", done_cnt - d0, 0);
    chk("post_rst_valid", out_valid, 0);

    // start and abort together: stays idle, no reads, no done.
    d0 = done_cnt;
    i0 = iss;
    start_addr = 8'd5;
    len = 9'd5;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("start_abort_iss", iss - i0, 0);
    chk("start_abort_done", done_cnt - d0, 0);

    // len = 0: done pulse only.
    i0 = iss;
    start_addr = 8'd7;
    len = 9'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    @(posedge clk); #1;
    chk("len0_done_pulse", done, 0);
    chk("len0_no_reads", iss - i0, 0);

`ifdef SD_READER_LOOP_EN
    // Loop three 4-sample blocks, then a single done.
    d0 = done_cnt;
    for (int b = 0; b < 3; b++) push_block(8'h20, 4);
    loop = 1'b1;
    pulse_start(8'h20, 4);
    t = 0;
    while ((xf - xf_base) < 9 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    loop = 1'b0;
    wait_done(d0);
    chk("loop_done_count", done_cnt - d0, 1);
    chk("loop_beats", xf - xf_base, 12);
    chk("loop_sb_empty", exp_q.size(), 0);
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
